// File: rtl/conta_regresivo.sv
// Loadable down-counter with IDLE/RUN/PAUSE/DONE control and terminal pulse.
// Define CONTA_AUTORELOAD_EN to restart from the last loaded value on terminal count.
module conta_regresivo #(
  parameter int LARGO = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             carga,
  input  logic [LARGO-1:0] valor,
  input  logic             inicio,
  input  logic             pausa,
  output logic [LARGO-1:0] cuenta,
  output logic             fin,
  output logic             activo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [LARGO-1:0] cuenta_q, cuenta_d;
  logic             fin_q, fin_d;

`ifdef CONTA_AUTORELOAD_EN
  logic [LARGO-1:0] recarga_q, recarga_d;

  always_ff @(posedge clk) begin
    if (rst) recarga_q <= '0;
    else     recarga_q <= recarga_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      cuenta_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cuenta_q <= cuenta_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    fin_d    = 1'b0;
`ifdef CONTA_AUTORELOAD_EN
    recarga_d = recarga_q;
`endif
    if (carga) begin
      cuenta_d = valor;
      estado_d = IDLE;
`ifdef CONTA_AUTORELOAD_EN
      recarga_d = valor;
`endif
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (inicio && cuenta_q != '0) estado_d = RUN;
        end
        RUN: begin
          if (pausa) begin
            estado_d = PAUSE;
          end else if (ena && cuenta_q > LARGO'(1)) begin
            cuenta_d = cuenta_q - LARGO'(1);
          end else if (ena && cuenta_q == LARGO'(1)) begin
            // terminal detection at 1 keeps the count from wrapping
            fin_d = 1'b1;
`ifdef CONTA_AUTORELOAD_EN
            if (recarga_q != '0) begin
              cuenta_d = recarga_q;
            end else begin
              cuenta_d = '0;
              estado_d = DONE;
            end
`else
            cuenta_d = '0;
            estado_d = DONE;
`endif
          end
        end
        PAUSE: begin
          if (!pausa) estado_d = RUN;
        end
        DONE: begin
          cuenta_d = '0;
        end
        default: begin
          estado_d = IDLE;
        end
      endcase
    end
  end

  assign cuenta = cuenta_q;
  assign fin    = fin_q;
  assign activo = (estado_q == RUN);

endmodule

// File: tb/tb_conta_regresivo.sv
// Directed vector table plus hand sequences for conta_regresivo.
// Expectations adapt when CONTA_AUTORELOAD_EN is defined.
module tb_conta_regresivo;

`ifdef CONTA_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       carga = 1'b0;
  logic [5:0] valor = '0;
  logic       inicio = 1'b0;
  logic       pausa = 1'b0;
  logic [5:0] cuenta;
  logic       fin;
  logic       activo;

  int checks = 0;
  int errors = 0;

  conta_regresivo #(.LARGO(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .carga  (carga),
    .valor  (valor),
    .inicio (inicio),
    .pausa  (pausa),
    .cuenta (cuenta),
    .fin    (fin),
    .activo (activo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       c;
    logic [5:0] v;
    logic       i;
    logic       p;
    logic       e;
    logic [5:0] ec;
    logic       ef;
    logic       ea;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic r, input logic c, input logic [5:0] v,
                      input logic i, input logic p, input logic e);
    @(negedge clk);
    rst = r; carga = c; valor = v;
    inicio = i; pausa = p; ena = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] ec,
                     input logic ef, input logic ea);
    checks++;
    if (cuenta !== ec || fin !== ef || activo !== ea) begin
      errors++;
      $display("FAIL %s: cuenta=%0d fin=%b activo=%b, expected cuenta=%0d fin=%b activo=%b",
               nm, cuenta, fin, activo, ec, ef, ea);
    end
  endtask

  initial begin
    logic [5:0] m;
    bit         hit;
    //                r  c  v   i  p  e   ec           ef    ea
    tbl.push_back('{1, 0, 0,  1, 0, 1,  0,           0,    0});
    tbl.push_back('{1, 0, 0,  1, 0, 1,  0,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 0, 0,  0,           0,    0});
    tbl.push_back('{0, 1, 5,  0, 0, 0,  5,           0,    0});
    tbl.push_back('{0, 0, 0,  1, 0, 0,  5,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  4,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  3,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 1, 1,  3,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 1, 1,  3,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 1, 1,  3,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 1, 1,  3,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  3,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  2,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  1,           0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  AR ? 6'd5 : 6'd0, 1, AR});
    tbl.push_back('{0, 1, 63, 0, 0, 1,  63,          0,    0});
    tbl.push_back('{0, 0, 0,  1, 0, 0,  63,          0,    1});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  62,          0,    1});
    tbl.push_back('{0, 1, 0,  0, 0, 0,  0,           0,    0});
    tbl.push_back('{0, 0, 0,  1, 0, 0,  0,           0,    0});
    tbl.push_back('{0, 0, 0,  1, 0, 1,  0,           0,    0});
    tbl.push_back('{0, 0, 0,  0, 0, 1,  0,           0,    0});

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].e);
      chk($sformatf("vec%0d", k), tbl[k].ec, tbl[k].ef, tbl[k].ea);
    end

    // valor=2 with ena every cycle: periodic with autoreload, else stops at 0
    step(0, 1, 2, 0, 0, 0);
    chk("load2", 2, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("start2", 2, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0, 1);
      chk($sformatf("run2_%0d", k),
          AR ? ((k % 2 == 0) ? 6'd1 : 6'd2) : ((k == 0) ? 6'd1 : 6'd0),
          AR ? (k % 2 == 1) : (k == 1),
          AR ? 1'b1 : (k == 0));
    end
`ifndef CONTA_AUTORELOAD_EN
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, k[0], k[1], 1);
      chk($sformatf("done_hold%0d", k), 0, 0, 0);
    end
`endif

    // ena every 4th cycle, reload with 63 while cuenta is 4
    step(0, 1, 10, 0, 0, 0);
    chk("load10", 10, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("start10", 10, 0, 1);
    m = 6'd10;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step(0, 0, 0, 0, 0, (k % 4) == 3);
      if ((k % 4) == 3) m = m - 6'd1;
      chk($sformatf("slow%0d", k), m, 0, 1);
      if (m == 6'd4) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL slow_reach4: cuenta=%0d, expected to reach 4", cuenta);
    end
    step(0, 1, 63, 0, 0, 1);
    chk("reload63", 63, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("start63", 63, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("dec63", 62, 0, 1);

    // inicio with pausa high in IDLE goes to RUN, then PAUSE
    step(0, 1, 4, 0, 0, 0);
    chk("load4", 4, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("start_paused", 4, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("to_pause", 4, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("resume", 4, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_dec", 3, 0, 1);

    // carga coinciding with a terminal event
    step(0, 1, 1, 0, 0, 0);
    chk("load1a", 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("start1a", 1, 0, 1);
    step(0, 1, 7, 0, 0, 1);
    chk("load_wins", 7, 0, 0);

    // rst coinciding with a terminal event
    step(0, 1, 1, 0, 0, 0);
    chk("load1b", 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("start1b", 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_wins", 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("after_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
